// File: rtl/lcd_mcu_bus_ctrl.sv
// lcd_mcu_bus_ctrl: Avalon-MM slave that queues LCD command/data/read requests
// and plays them out as 8080-style CS/RS/WR/RD bus cycles with programmable timing.
// Optional build macro LCD_READ_SYNC_EN: 2-flop synchronizer on lcd_data_i and
// read strobe lengthened by two clocks to cover the synchronizer latency.
module lcd_mcu_bus_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned T_SETUP    = 1,
   parameter int unsigned T_STROBE   = 2,
   parameter int unsigned T_HOLD     = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   output logic        avs_waitrequest,
   output logic        lcd_cs_n,
   output logic        lcd_rs,
   output logic        lcd_wr_n,
   output logic        lcd_rd_n,
   output logic [15:0] lcd_data_o,
   output logic        lcd_data_oe,
   input  logic [15:0] lcd_data_i,
   output logic [15:0] rd_data,
   output logic        rd_valid
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LVL_W = PTR_W + 1;
`ifdef LCD_READ_SYNC_EN
   localparam int unsigned T_RD_STROBE = T_STROBE + 2;
`else
   localparam int unsigned T_RD_STROBE = T_STROBE;
`endif
   localparam int unsigned T_MAX_SH = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
   localparam int unsigned T_MAX    = (T_MAX_SH > T_RD_STROBE) ? T_MAX_SH : T_RD_STROBE;
   localparam int unsigned CNT_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   typedef struct packed {
      logic        is_read;
      logic        rs;
      logic [15:0] data;
   } entry_t;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   // ---------------------------------------------------------------- request FIFO
   entry_t             mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic               fifo_empty_c, fifo_full_c, push_c, pop_c;
   entry_t             push_entry_c;
   logic               unused_wd_c;

   assign fifo_empty_c    = (level_q == '0);
   assign fifo_full_c     = (level_q == LVL_W'(FIFO_DEPTH));
   assign avs_waitrequest = avs_write & fifo_full_c;
   assign push_c          = avs_write & ~fifo_full_c & (avs_address != 2'd3);
   assign unused_wd_c     = ^avs_writedata[31:16];

   // Translate the register address into a queued bus request
   always_comb begin
      push_entry_c = '0;
      case (avs_address)
         2'd0:    push_entry_c = '{is_read: 1'b0, rs: 1'b0, data: avs_writedata[15:0]};
         2'd1:    push_entry_c = '{is_read: 1'b0, rs: 1'b1, data: avs_writedata[15:0]};
         2'd2:    push_entry_c = '{is_read: 1'b1, rs: avs_writedata[0], data: 16'h0000};
         default: push_entry_c = '0;
      endcase
   end

   // FIFO storage (no reset needed, validity tracked by level)
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= push_entry_c;
   end

   // FIFO pointers and fill level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // ---------------------------------------------------------------- read sample path
   logic [15:0] sample_c;
`ifdef LCD_READ_SYNC_EN
   logic [15:0] sync1_q, sync2_q;

   // Two-flop synchronizer for the asynchronous LCD read bus
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= lcd_data_i;
         sync2_q <= sync1_q;
      end
   end
   assign sample_c = sync2_q;
`else
   assign sample_c = lcd_data_i;
`endif

   // ---------------------------------------------------------------- bus sequencer
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   entry_t           entry_q, entry_d;
   logic             capture_c;
   logic             cs_n_q, cs_n_d, rs_q, rs_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d, oe_q, oe_d;
   logic [15:0]      data_q, data_d;

   // Phase sequencing; bus outputs are derived from the next state so they
   // change on the same edge as the state register
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      entry_d   = entry_q;
      pop_c     = 1'b0;
      capture_c = 1'b0;
      cs_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      rd_n_d    = 1'b1;
      oe_d      = 1'b0;
      rs_d      = rs_q;
      data_d    = data_q;

      case (state_q)
         IDLE: begin
            if (!fifo_empty_c) begin
               pop_c   = 1'b1;
               entry_d = mem_q[rd_ptr_q];
               state_d = SETUP;
               cnt_d   = CNT_W'(T_SETUP - 1);
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = entry_q.is_read ? CNT_W'(T_RD_STROBE - 1) : CNT_W'(T_STROBE - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               capture_c = entry_q.is_read;
               state_d   = HOLD;
               cnt_d     = CNT_W'(T_HOLD - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               if (!fifo_empty_c) begin
                  pop_c   = 1'b1;
                  entry_d = mem_q[rd_ptr_q];
                  state_d = SETUP;
                  cnt_d   = CNT_W'(T_SETUP - 1);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != IDLE) begin
         cs_n_d = 1'b0;
         rs_d   = entry_d.rs;
         data_d = entry_d.data;
         oe_d   = ~entry_d.is_read;
         if (state_d == STROBE) begin
            wr_n_d = entry_d.is_read;
            rd_n_d = ~entry_d.is_read;
         end
      end
   end

   // Sequencer state and registered LCD outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         entry_q <= '0;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         rs_q    <= 1'b0;
         oe_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         entry_q <= entry_d;
         cs_n_q  <= cs_n_d;
         wr_n_q  <= wr_n_d;
         rd_n_q  <= rd_n_d;
         rs_q    <= rs_d;
         oe_q    <= oe_d;
         data_q  <= data_d;
      end
   end

   // ---------------------------------------------------------------- read capture and register map
   logic [15:0] rd_data_q;
   logic        rd_valid_q;
   logic [31:0] readdata_q, readdata_c;
   logic        busy_c;

   assign busy_c = (state_q != IDLE) | ~fifo_empty_c;

   // Register read mux
   always_comb begin
      readdata_c = '0;
      case (avs_address)
         2'd2:    readdata_c = {16'h0000, rd_data_q};
         2'd3:    readdata_c = {26'h0, busy_c, fifo_full_c, fifo_empty_c, 3'(level_q)};
         default: readdata_c = '0;
      endcase
   end

   // Captured read word, its valid pulse and the Avalon read register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         readdata_q <= '0;
      end else begin
         rd_valid_q <= capture_c;
         if (capture_c) rd_data_q  <= sample_c;
         if (avs_read)  readdata_q <= readdata_c;
      end
   end

   assign lcd_cs_n     = cs_n_q;
   assign lcd_rs       = rs_q;
   assign lcd_wr_n     = wr_n_q;
   assign lcd_rd_n     = rd_n_q;
   assign lcd_data_o   = data_q;
   assign lcd_data_oe  = oe_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign avs_readdata = readdata_q;

endmodule
